text_overlay_arbiter: RTL and testbench

//  N-channel text overlay engine for the VGA sale-terminal display. Each client (product-ID

---
 rtl/text_overlay_arbiter_pkg.sv | 32 +++
 rtl/text_overlay_arbiter_pipe_delay.sv | 25 ++
 rtl/text_overlay_arbiter.sv | 173 +++++++++++++++++
 tb/tb_text_overlay_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_overlay_arbiter_pkg.sv
// Shared definitions for the text overlay arbiter: channel-id width, visible-area defaults,
// font address width helper and the fixed-priority encoder.
package text_overlay_arbiter_pkg;

    localparam int CH_ID_W      = 3;
    localparam int MAX_CH       = 8;
    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 600;

    typedef struct packed {
        logic               found;
        logic [CH_ID_W-1:0] idx;
    } winner_t;

    function automatic int font_addr_w(input int char_w, input int row_w);
        return char_w + row_w;
    endfunction

    // Scans downwards so the lowest set index is the one left standing.
    function automatic winner_t first_set(input logic [MAX_CH-1:0] req);
        winner_t w;
        w = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                w.found = 1'b1;
                w.idx   = CH_ID_W'(i);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/text_overlay_arbiter_pipe_delay.sv
// Fixed-depth shift register that carries the per-pixel side-band fields past the font ROM.
module text_pipe_delay #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] shift_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) shift_q[i] <= '0;
        end else begin
            shift_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) shift_q[i] <= shift_q[i-1];
        end
    end

    assign q_o = shift_q[DEPTH-1];

endmodule

// File: rtl/text_overlay_arbiter.sv
// N-channel text overlay engine: fixed-priority arbitration onto a shared synchronous font ROM,
// glyph bit extraction aligned with delayed H/V counters, and a per-frame collision counter.
module text_overlay_arbiter
    import text_overlay_arbiter_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int CHAR_W      = 7,
    parameter int ROW_W       = 4,
    parameter int FONT_W      = 8,
    parameter int COL_W       = 3,
    parameter int ROM_LATENCY = 1,
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [10:0]             H_counter,
    input  logic [9:0]              V_counter,
    input  logic [N_CH-1:0]         ch_valid,
    input  logic [N_CH-1:0]         ch_enable,
    input  logic [N_CH*CHAR_W-1:0]  ch_char,
    input  logic [N_CH*ROW_W-1:0]   ch_row,
    input  logic [N_CH*COL_W-1:0]   ch_col,
    output logic [CHAR_W+ROW_W-1:0] rom_addr,
    input  logic [FONT_W-1:0]       rom_data,
    output logic                    pixel_on,
    output logic [CH_ID_W-1:0]      pixel_ch,
    output logic                    pixel_valid,
    output logic [10:0]             H_out,
    output logic [9:0]              V_out,
    output logic [15:0]             collision_count
);

    localparam int ADDR_W = font_addr_w(CHAR_W, ROW_W);
    localparam int PIPE_W = COL_W + CH_ID_W + 1 + 11 + 10;

    logic [N_CH-1:0]   req;
    logic              active;
    logic              frame_start;
    logic              coll;
    winner_t           win;
    logic [CHAR_W-1:0] sel_char;
    logic [ROW_W-1:0]  sel_row;
    logic [COL_W-1:0]  sel_col;

    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [COL_W-1:0]   col_a_q;
    logic [CH_ID_W-1:0] ch_a_q;
    logic               vld_a_q;
    logic [10:0]        h_a_q;
    logic [9:0]         v_a_q;

    logic [PIPE_W-1:0]  pipe_in, pipe_out;
    logic [COL_W-1:0]   col_b;
    logic [CH_ID_W-1:0] ch_b;
    logic               vld_b;
    logic [10:0]        h_b;
    logic [9:0]         v_b;
    logic [COL_W-1:0]   bit_idx;

    logic [FONT_W-1:0]  rom_q;
    logic               pixel_on_q, pixel_valid_q;
    logic [CH_ID_W-1:0] pixel_ch_q;
    logic [10:0]        h_out_q;
    logic [9:0]         v_out_q;

    logic [15:0]        running_q, running_d;
    logic [15:0]        count_q, count_d;

    always_comb begin
        active      = (H_counter < 11'(H_ACTIVE)) && (V_counter < 10'(V_ACTIVE));
        frame_start = (H_counter == 11'd0) && (V_counter == 10'd0);
        req         = active ? (ch_valid & ch_enable) : '0;
        win         = first_set(MAX_CH'(req));
        coll        = ($countones(req) >= 2);
        sel_char    = '0;
        sel_row     = '0;
        sel_col     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (win.found && (win.idx == CH_ID_W'(i))) begin
                sel_char = ch_char[i*CHAR_W +: CHAR_W];
                sel_row  = ch_row[i*ROW_W +: ROW_W];
                sel_col  = ch_col[i*COL_W +: COL_W];
            end
        end
        rom_addr_d = win.found ? {sel_char, sel_row} : rom_addr_q;
    end

    // Stage A: arbitration result and ROM address
    always_ff @(posedge CLK) begin
        if (RST) begin
            rom_addr_q <= '0;
            col_a_q    <= '0;
            ch_a_q     <= '0;
            vld_a_q    <= 1'b0;
            h_a_q      <= '0;
            v_a_q      <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            col_a_q    <= sel_col;
            ch_a_q     <= win.idx;
            vld_a_q    <= win.found;
            h_a_q      <= H_counter;
            v_a_q      <= V_counter;
        end
    end

    // Delay line: ROM latency plus the rom_data capture register
    assign pipe_in = {col_a_q, ch_a_q, vld_a_q, h_a_q, v_a_q};

    text_pipe_delay #(
        .W     (PIPE_W),
        .DEPTH (ROM_LATENCY + 1)
    ) u_delay (
        .CLK (CLK),
        .RST (RST),
        .d_i (pipe_in),
        .q_o (pipe_out)
    );

    assign {col_b, ch_b, vld_b, h_b, v_b} = pipe_out;
    assign bit_idx = COL_W'(FONT_W - 1) - col_b;

    // Output stage: column 0 is the MSB of the glyph row
    always_ff @(posedge CLK) begin
        if (RST) begin
            rom_q         <= '0;
            pixel_on_q    <= 1'b0;
            pixel_ch_q    <= '0;
            pixel_valid_q <= 1'b0;
            h_out_q       <= '0;
            v_out_q       <= '0;
        end else begin
            rom_q         <= rom_data;
            pixel_on_q    <= vld_b & rom_q[bit_idx];
            pixel_ch_q    <= vld_b ? ch_b : '0;
            pixel_valid_q <= vld_b;
            h_out_q       <= h_b;
            v_out_q       <= v_b;
        end
    end

    // A collision on the frame-start cycle belongs to the frame that is just beginning.
    always_comb begin
        running_d = running_q;
        count_d   = count_q;
        if (frame_start) begin
            count_d   = running_q;
            running_d = coll ? 16'd1 : 16'd0;
        end else if (coll && (running_q != 16'hFFFF)) begin
            running_d = running_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            running_q <= '0;
            count_q   <= '0;
        end else begin
            running_q <= running_d;
            count_q   <= count_d;
        end
    end

    assign rom_addr        = rom_addr_q;
    assign pixel_on        = pixel_on_q;
    assign pixel_ch        = pixel_ch_q;
    assign pixel_valid     = pixel_valid_q;
    assign H_out           = h_out_q;
    assign V_out           = v_out_q;
    assign collision_count = count_q;

endmodule

// File: tb/tb_text_overlay_arbiter.sv
// Bench for text_overlay_arbiter: two instances (ROM latency 1 and 2) share stimulus, each with a
// behavioural font ROM; directed scenarios plus randomized traffic against a latency-window model.
`timescale 1ns/1ps
module tb_text_overlay_arbiter;

    localparam int N_CH = 2, CHAR_W = 7, ROW_W = 4, FONT_W = 8, COL_W = 3;
    localparam int AW = CHAR_W + ROW_W;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [10:0]            H = '0;
    logic [9:0]             V = '0;
    logic [N_CH-1:0]        ch_valid = '0, ch_enable = '1;
    logic [N_CH*CHAR_W-1:0] ch_char = '0;
    logic [N_CH*ROW_W-1:0]  ch_row = '0;
    logic [N_CH*COL_W-1:0]  ch_col = '0;

    logic [AW-1:0] rom_addr1, rom_addr2;
    logic [7:0]    rom_data1, rom_data2;
    logic          pixel_on1, pixel_valid1, pixel_on2, pixel_valid2;
    logic [2:0]    pixel_ch1, pixel_ch2;
    logic [10:0]   H_out1, H_out2;
    logic [9:0]    V_out1, V_out2;
    logic [15:0]   cc1, cc2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    text_overlay_arbiter #(.N_CH(N_CH), .ROM_LATENCY(1)) dut1 (
        .CLK(clk), .RST(rst), .H_counter(H), .V_counter(V),
        .ch_valid(ch_valid), .ch_enable(ch_enable), .ch_char(ch_char), .ch_row(ch_row), .ch_col(ch_col),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .pixel_on(pixel_on1), .pixel_ch(pixel_ch1),
        .pixel_valid(pixel_valid1), .H_out(H_out1), .V_out(V_out1), .collision_count(cc1)
    );

    text_overlay_arbiter #(.N_CH(N_CH), .ROM_LATENCY(2)) dut2 (
        .CLK(clk), .RST(rst), .H_counter(H), .V_counter(V),
        .ch_valid(ch_valid), .ch_enable(ch_enable), .ch_char(ch_char), .ch_row(ch_row), .ch_col(ch_col),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .pixel_on(pixel_on2), .pixel_ch(pixel_ch2),
        .pixel_valid(pixel_valid2), .H_out(H_out2), .V_out(V_out2), .collision_count(cc2)
    );

    function automatic logic [7:0] rom_word(input logic [AW-1:0] a);
        if (a == {7'h41, 4'd5}) return 8'h80;
        return 8'(a * 11'd37) ^ 8'(a >> 3);
    endfunction

    logic [7:0] rom1_q;
    logic [7:0] rom2_q [2];
    always @(posedge clk) begin
        rom1_q    <= rom_word(rom_addr1);
        rom2_q[0] <= rom_word(rom_addr2);
        rom2_q[1] <= rom2_q[0];
    end
    assign rom_data1 = rom1_q;
    assign rom_data2 = rom2_q[1];

    // Reference model: per-edge outcome history; an output shows the outcome from L+2 edges
    // earlier unless reset was seen anywhere in that window.
    int          e = 0;
    bit          hr  [16] = '{default: 1'b1};
    logic        hv  [16];
    logic        ho  [16];
    logic [2:0]  hc  [16];
    logic [10:0] hh  [16];
    logic [9:0]  hvv [16];
    logic        ex_vld [3];
    logic        ex_on  [3];
    logic [2:0]  ex_ch  [3];
    logic [10:0] ex_h   [3];
    logic [9:0]  ex_v   [3];
    logic [15:0] m_run = '0, m_cc = '0;
    logic [AW-1:0] m_addr = '0;

    always @(posedge clk) begin
        int slot, cnt, w, src, col;
        bit act, z;
        logic [AW-1:0] a;
        logic [7:0] word;
        slot = e % 16;
        act  = (H < 11'd800) && (V < 10'd600);
        cnt  = 0;
        w    = -1;
        for (int i = 0; i < N_CH; i++) begin
            if (act && ch_valid[i] && ch_enable[i]) begin
                cnt++;
                if (w < 0) w = i;
            end
        end
        hr[slot]  = rst;
        hh[slot]  = H;
        hvv[slot] = V;
        hv[slot]  = (w >= 0);
        hc[slot]  = '0;
        ho[slot]  = 1'b0;
        if (w >= 0) begin
            a    = {ch_char[w*CHAR_W +: CHAR_W], ch_row[w*ROW_W +: ROW_W]};
            col  = int'(ch_col[w*COL_W +: COL_W]);
            word = rom_word(a);
            hc[slot] = 3'(w);
            ho[slot] = word[7 - col];
            if (!rst) m_addr = a;
        end
        if (rst) m_addr = '0;
        if (rst) begin
            m_run = '0;
            m_cc  = '0;
        end else if (H == 11'd0 && V == 10'd0) begin
            m_cc  = m_run;
            m_run = (cnt >= 2) ? 16'd1 : 16'd0;
        end else if (cnt >= 2 && m_run != 16'hFFFF) begin
            m_run = m_run + 16'd1;
        end
        for (int L = 1; L <= 2; L++) begin
            src = e - L - 2;
            z   = (src < 0);
            for (int k = src; k <= e; k++) if (k >= 0 && hr[k % 16]) z = 1'b1;
            if (z) begin
                ex_vld[L] = 1'b0; ex_on[L] = 1'b0; ex_ch[L] = '0; ex_h[L] = '0; ex_v[L] = '0;
            end else begin
                ex_vld[L] = hv[src % 16]; ex_on[L] = ho[src % 16]; ex_ch[L] = hc[src % 16];
                ex_h[L] = hh[src % 16]; ex_v[L] = hvv[src % 16];
            end
        end
        e++;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        ch_valid = '0;
        H = H + 11'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ch_valid = '1; ch_enable = '1;
        ch_char = {7'h12, 7'h34}; ch_row = {4'd3, 4'd9}; ch_col = '0;
        H = 11'd10; V = 10'd10;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({pixel_on1, pixel_valid1, pixel_ch1, H_out1, V_out1, cc1, rom_addr1,
                 pixel_on2, pixel_valid2, pixel_ch2, H_out2, V_out2, cc2, rom_addr2} !== '0) begin
                bad++;
                $display("FAIL reset_hold cyc%0d: got on=%b vld=%b ch=%0d H=%0d V=%0d cc=%0d addr=%h, want all 0",
                         i, pixel_on1, pixel_valid1, pixel_ch1, H_out1, V_out1, cc1, rom_addr1);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            H = H + 11'd1;
            tick();
            total++;
            if ({pixel_on1, pixel_valid1, pixel_ch1, H_out1, V_out1, cc1,
                 pixel_on2, pixel_valid2, pixel_ch2, H_out2, V_out2, cc2} !== '0) begin
                bad++;
                $display("FAIL reset_release cyc%0d: got vld1=%b H1=%0d vld2=%b H2=%0d, want all 0",
                         i, pixel_valid1, H_out1, pixel_valid2, H_out2);
            end
        end
        H = H + 11'd1;
        tick();
        total++;
        if (pixel_valid1 !== 1'b1 || pixel_ch1 !== 3'd0 || H_out1 !== 11'd11) begin
            bad++;
            $display("FAIL reset_first_valid: got vld=%b ch=%0d H=%0d, want 1 0 11", pixel_valid1, pixel_ch1, H_out1);
        end
        for (int i = 0; i < 5; i++) begin idle(); tick(); end
    endtask

    task automatic test_single();
        for (int c = 0; c < 2; c++) begin
            ch_enable = 2'b11; ch_valid = 2'b01;
            ch_char[6:0] = 7'h41; ch_row[3:0] = 4'd5; ch_col[2:0] = 3'(c);
            H = 11'd100; V = 10'd50;
            tick();
            total++;
            if (rom_addr1 !== 11'h415) begin
                bad++; $display("FAIL single_addr: got %h want 415", rom_addr1);
            end
            idle(); tick();
            tick();
            total++;
            if (pixel_valid1 !== 1'b0) begin
                bad++; $display("FAIL single_early: got vld=%b want 0", pixel_valid1);
            end
            tick();
            total++;
            if (pixel_on1 !== (c == 0) || pixel_ch1 !== 3'd0 || pixel_valid1 !== 1'b1 ||
                H_out1 !== 11'd100 || V_out1 !== 10'd50) begin
                bad++;
                $display("FAIL single_l1 col%0d: got on=%b ch=%0d vld=%b H=%0d V=%0d, want on=%0d ch=0 vld=1 H=100 V=50",
                         c, pixel_on1, pixel_ch1, pixel_valid1, H_out1, V_out1, (c == 0));
            end
            tick();
            total++;
            if (pixel_on2 !== (c == 0) || pixel_valid2 !== 1'b1 || H_out2 !== 11'd100 || V_out2 !== 10'd50) begin
                bad++;
                $display("FAIL single_l2 col%0d: got on=%b vld=%b H=%0d V=%0d, want on=%0d vld=1 H=100 V=50",
                         c, pixel_on2, pixel_valid2, H_out2, V_out2, (c == 0));
            end
            tick();
        end
    endtask

    task automatic test_priority();
        for (int p = 0; p < 2; p++) begin
            ch_enable = (p == 0) ? 2'b11 : 2'b10;
            ch_valid  = 2'b11;
            ch_char   = {7'h22, 7'h11}; ch_row = {4'd3, 4'd2}; ch_col = '0;
            H = 11'd200; V = 10'd60;
            tick();
            total++;
            if (rom_addr1 !== ((p == 0) ? {7'h11, 4'd2} : {7'h22, 4'd3})) begin
                bad++; $display("FAIL prio_addr en%0d: got %h", p, rom_addr1);
            end
            idle(); tick(); tick(); tick();
            total++;
            if (pixel_ch1 !== 3'(p) || pixel_valid1 !== 1'b1) begin
                bad++; $display("FAIL prio_ch en%0d: got ch=%0d vld=%b, want ch=%0d vld=1", p, pixel_ch1, pixel_valid1, p);
            end
            tick();
        end
        ch_enable = 2'b11;
    endtask

    task automatic test_blanking();
        for (int b = 0; b < 2; b++) begin
            ch_valid = 2'b11;
            H = (b == 0) ? 11'd800 : 11'd5;
            V = (b == 0) ? 10'd10 : 10'd600;
            tick();
            idle(); tick(); tick(); tick();
            total++;
            if (pixel_valid1 !== 1'b0 || pixel_on1 !== 1'b0 || pixel_ch1 !== 3'd0) begin
                bad++; $display("FAIL blank_l1 case%0d: got vld=%b on=%b ch=%0d, want 0", b, pixel_valid1, pixel_on1, pixel_ch1);
            end
            tick();
            total++;
            if (pixel_valid2 !== 1'b0 || pixel_on2 !== 1'b0) begin
                bad++; $display("FAIL blank_l2 case%0d: got vld=%b on=%b, want 0", b, pixel_valid2, pixel_on2);
            end
        end
        V = 10'd20;
    endtask

    task automatic test_collision();
        ch_enable = 2'b11; ch_valid = '0; H = '0; V = '0;
        tick();
        V = 10'd5;
        for (int i = 0; i < 37; i++) begin ch_valid = 2'b11; H = 11'(10 + i); tick(); end
        ch_valid = 2'b11; H = 11'd800; tick();
        H = 11'd3; V = 10'd600; tick();
        V = 10'd5; ch_enable = 2'b01; H = 11'd60; tick();
        ch_enable = 2'b11; ch_valid = 2'b01; H = 11'd61; tick();
        ch_valid = '0; H = '0; V = '0; tick();
        total++;
        if (cc1 !== 16'd37 || cc2 !== 16'd37) begin
            bad++; $display("FAIL coll_37: got %0d/%0d want 37", cc1, cc2);
        end
        V = 10'd7; H = 11'd5; tick();
        ch_valid = 2'b11; H = '0; V = '0; tick();
        total++;
        if (cc1 !== 16'd0) begin
            bad++; $display("FAIL coll_fs_cur: got %0d want 0", cc1);
        end
        V = 10'd7;
        for (int i = 0; i < 4; i++) begin H = 11'(20 + i); tick(); end
        ch_valid = '0; H = '0; V = '0; tick();
        total++;
        if (cc1 !== 16'd5) begin
            bad++; $display("FAIL coll_fs_next: got %0d want 5", cc1);
        end
        V = 10'd7; ch_valid = 2'b11;
        for (int i = 0; i < 70000; i++) begin H = 11'(1 + (i % 700)); tick(); end
        ch_valid = '0; H = '0; V = '0; tick();
        total++;
        if (cc1 !== 16'hFFFF || cc2 !== 16'hFFFF) begin
            bad++; $display("FAIL coll_sat: got %h/%h want ffff", cc1, cc2);
        end
        V = 10'd30; H = 11'd1;
    endtask

    task automatic test_back_to_back();
        logic [6:0] chs [8];
        logic [2:0] cols [8];
        logic [7:0] word;
        for (int i = 0; i < 8; i++) begin
            chs[i]  = 7'($urandom);
            cols[i] = 3'($urandom);
        end
        ch_enable = 2'b11;
        for (int t = 0; t < 13; t++) begin
            if (t < 8) begin
                ch_valid = 2'b01; ch_char[6:0] = chs[t]; ch_row[3:0] = 4'd7; ch_col[2:0] = cols[t];
                H = 11'(300 + t); V = 10'd70;
            end else begin
                ch_valid = '0; H = 11'(400 + t);
            end
            tick();
            if (t >= 3 && t < 11) begin
                word = rom_word({chs[t-3], 4'd7});
                total++;
                if (pixel_valid1 !== 1'b1 || H_out1 !== 11'(300 + t - 3) || pixel_on1 !== word[7 - int'(cols[t-3])]) begin
                    bad++; $display("FAIL b2b_l1 t%0d: got vld=%b H=%0d on=%b want vld=1 H=%0d on=%b",
                                    t, pixel_valid1, H_out1, pixel_on1, 300 + t - 3, word[7 - int'(cols[t-3])]);
                end
            end
            if (t >= 4 && t < 12) begin
                word = rom_word({chs[t-4], 4'd7});
                total++;
                if (pixel_valid2 !== 1'b1 || H_out2 !== 11'(300 + t - 4) || pixel_on2 !== word[7 - int'(cols[t-4])]) begin
                    bad++; $display("FAIL b2b_l2 t%0d: got vld=%b H=%0d on=%b want vld=1 H=%0d on=%b",
                                    t, pixel_valid2, H_out2, pixel_on2, 300 + t - 4, word[7 - int'(cols[t-4])]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 2500; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 39) == 0) begin
                H = '0; V = '0;
            end else begin
                H = 11'($urandom_range(0, 849));
                V = 10'($urandom_range(0, 619));
            end
            ch_valid  = 2'($urandom);
            ch_enable = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            ch_char   = 14'($urandom);
            ch_row    = 8'($urandom);
            ch_col    = 6'($urandom);
            tick();
            total++;
            if ({pixel_valid1, pixel_on1, pixel_ch1, H_out1, V_out1} !==
                {ex_vld[1], ex_on[1], ex_ch[1], ex_h[1], ex_v[1]}) begin
                bad++; $display("FAIL rnd_l1 n%0d: got vld=%b on=%b ch=%0d H=%0d V=%0d want vld=%b on=%b ch=%0d H=%0d V=%0d",
                                n, pixel_valid1, pixel_on1, pixel_ch1, H_out1, V_out1,
                                ex_vld[1], ex_on[1], ex_ch[1], ex_h[1], ex_v[1]);
            end
            total++;
            if ({pixel_valid2, pixel_on2, pixel_ch2, H_out2, V_out2} !==
                {ex_vld[2], ex_on[2], ex_ch[2], ex_h[2], ex_v[2]}) begin
                bad++; $display("FAIL rnd_l2 n%0d: got vld=%b on=%b ch=%0d H=%0d V=%0d want vld=%b on=%b ch=%0d H=%0d V=%0d",
                                n, pixel_valid2, pixel_on2, pixel_ch2, H_out2, V_out2,
                                ex_vld[2], ex_on[2], ex_ch[2], ex_h[2], ex_v[2]);
            end
            total++;
            if (cc1 !== m_cc || cc2 !== m_cc || rom_addr1 !== m_addr || rom_addr2 !== m_addr) begin
                bad++; $display("FAIL rnd_cc_addr n%0d: got cc=%0d/%0d addr=%h/%h want cc=%0d addr=%h",
                                n, cc1, cc2, rom_addr1, rom_addr2, m_cc, m_addr);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_blanking();
        test_collision();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
